muldiv_unit: RTL and testbench

Iterative multi-cycle multiply/divide engine for the execute stage, serving MULT, MULTU, DIV and DIVU.
- Generalises the fixed radix-4 32-bit divider: parametrised data width and radix, iterative multiply, explicit start/done/flush handshake, div-by-zero flag.
- Execute stage drives start and holds its stall request until done.
- Results go to the HI/LO write path.

---
 rtl/muldiv_unit_pkg.sv | 31 +++
 rtl/muldiv_unit_if.sv | 29 ++
 rtl/muldiv_unit_step.sv | 59 +++++
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operations, FSM states
// and a zero word used for register resets.
package muldiv_unit_pkg;

   typedef enum logic [1:0] {
      MDU_OP_MULT  = 2'b00,
      MDU_OP_MULTU = 2'b01,
      MDU_OP_DIV   = 2'b10,
      MDU_OP_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_CALC = 2'b01,
      MDU_FIX  = 2'b10,
      MDU_DONE = 2'b11
   } mdu_state_e;

   localparam int MDU_MAX_W = 64;
   localparam logic [MDU_MAX_W-1:0] MDU_ZERO_WORD = '0;

   function automatic logic op_is_div(input mdu_op_e op);
      return op[1];
   endfunction

   // Even encodings are the signed variants.
   function automatic logic op_is_signed(input mdu_op_e op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage <-> multiply/divide unit handshake: request, operands, flush,
// status and the HI/LO result bus.
interface muldiv_unit_if #(
   parameter int DATA_W = 32
);
   import muldiv_unit_pkg::*;

   logic              start_i;
   logic [1:0]        op_i;
   logic [DATA_W-1:0] src1_i;
   logic [DATA_W-1:0] src2_i;
   logic              flush_i;
   logic              busy_o;
   logic              done_o;
   logic [DATA_W-1:0] hi_o;
   logic [DATA_W-1:0] lo_o;
   logic              dbz_o;

   modport master (
      output start_i, op_i, src1_i, src2_i, flush_i,
      input  busy_o, done_o, hi_o, lo_o, dbz_o
   );

   modport slave (
      input  start_i, op_i, src1_i, src2_i, flush_i,
      output busy_o, done_o, hi_o, lo_o, dbz_o
   );

endinterface

// File: rtl/muldiv_unit_step.sv
// One combinational iteration of the multiply/divide engine: retires STEP_BITS
// quotient bits (restoring divide) or STEP_BITS multiplier bits (shift-add).
module muldiv_step
   import muldiv_unit_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int STEP_BITS = 2
) (
   input  logic              div_mode,
   input  logic [DATA_W-1:0] acc_hi,
   input  logic [DATA_W-1:0] acc_lo,
   input  logic [DATA_W-1:0] operand,
   output logic [DATA_W-1:0] next_hi,
   output logic [DATA_W-1:0] next_lo
);
   localparam int EXT_W  = DATA_W + STEP_BITS;
   localparam int DIGITS = 2 ** STEP_BITS;

   logic [EXT_W-1:0]     op_ext;
   logic [EXT_W-1:0]     part;
   logic [EXT_W-1:0]     multiple;
   logic [EXT_W-1:0]     mul_sum;
   logic [DATA_W-1:0]    rem_next;
   logic [STEP_BITS-1:0] q_digit;

   assign op_ext = {{STEP_BITS{1'b0}}, operand};

   // Divide: acc_hi is the partial remainder, acc_lo shifts the dividend out the
   // top while quotient digits enter at the bottom.
   assign part = {acc_hi, acc_lo[DATA_W-1 -: STEP_BITS]};

   always_comb begin
      rem_next = part[DATA_W-1:0];
      q_digit  = '0;
      multiple = '0;
      for (int k = 1; k < DIGITS; k++) begin
         multiple = multiple + op_ext;
         if (part >= multiple) begin
            // The difference is below the divisor, so the low word is exact.
            rem_next = part[DATA_W-1:0] - multiple[DATA_W-1:0];
            q_digit  = STEP_BITS'(k);
         end
      end
   end

   // Multiply: LSB-first digit of the multiplier in acc_lo, product shifts right.
   assign mul_sum = {{STEP_BITS{1'b0}}, acc_hi} + op_ext * EXT_W'(acc_lo[STEP_BITS-1:0]);

   always_comb begin
      if (div_mode) begin
         next_hi = rem_next;
         next_lo = {acc_lo[DATA_W-STEP_BITS-1:0], q_digit};
      end else begin
         next_hi = mul_sum[EXT_W-1:STEP_BITS];
         next_lo = {mul_sum[STEP_BITS-1:0], acc_lo[DATA_W-1:STEP_BITS]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with start/done/flush handshake and HI/LO
// result registers. Define MULDIV_EARLY_OUT_EN to short-cut divides with |dividend| < |divisor|.
//
// state    | meaning
// ---------+------------------------------------------------------------
// MDU_IDLE | waiting for start_i; results held
// MDU_CALC | one step per cycle, ITER cycles
// MDU_FIX  | sign correction / divide-by-zero result, outputs registered
// MDU_DONE | done_o pulse; accepts a new start like IDLE
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int STEP_BITS = 2
) (
   input  logic         cpu_clk_50M,
   input  logic         cpu_rst_n,
   muldiv_unit_if.slave mdu
);
   localparam int ITER  = DATA_W / STEP_BITS;
   localparam int CNT_W = $clog2(ITER + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   mdu_state_e        state_q, state_d;
   mdu_op_e           op_in;
   logic              in_div, in_signed, div_zero, early_out, accept;
   logic [DATA_W-1:0] mag1, mag2;

   logic [CNT_W-1:0]  cnt_q;
   logic              div_q, neg_res_q, neg_rem_q, dbz_q;
   logic [DATA_W-1:0] acc_hi_q, acc_lo_q, opnd_q;
   logic [DATA_W-1:0] step_hi, step_lo;

   logic [DATA_W-1:0]   hi_q, lo_q;
   logic                dbz_out_q;
   logic [2*DATA_W-1:0] prod_raw;

   assign op_in     = mdu_op_e'(mdu.op_i);
   assign in_div    = op_is_div(op_in);
   assign in_signed = op_is_signed(op_in);
   assign mag1      = (in_signed && mdu.src1_i[DATA_W-1]) ? -mdu.src1_i : mdu.src1_i;
   assign mag2      = (in_signed && mdu.src2_i[DATA_W-1]) ? -mdu.src2_i : mdu.src2_i;
   assign div_zero  = in_div && (mdu.src2_i == MDU_ZERO_WORD[DATA_W-1:0]);
   assign accept    = mdu.start_i && !mdu.flush_i &&
                      ((state_q == MDU_IDLE) || (state_q == MDU_DONE));

`ifdef MULDIV_EARLY_OUT_EN
   assign early_out = in_div && !div_zero && (mag1 < mag2);
`else
   assign early_out = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         MDU_IDLE, MDU_DONE: begin
            if (accept)
               state_d = (div_zero || early_out) ? MDU_FIX : MDU_CALC;
            else
               state_d = MDU_IDLE;
         end
         MDU_CALC: begin
            if (mdu.flush_i)
               state_d = MDU_IDLE;
            else if (cnt_q == '0)
               state_d = MDU_FIX;
         end
         MDU_FIX:  state_d = mdu.flush_i ? MDU_IDLE : MDU_DONE;
         default:  state_d = MDU_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q   <= MDU_IDLE;
         cnt_q     <= '0;
         div_q     <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         acc_hi_q  <= MDU_ZERO_WORD[DATA_W-1:0];
         acc_lo_q  <= MDU_ZERO_WORD[DATA_W-1:0];
         opnd_q    <= MDU_ZERO_WORD[DATA_W-1:0];
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q     <= CNT_LAST;
            div_q     <= in_div;
            neg_res_q <= in_signed && (mdu.src1_i[DATA_W-1] ^ mdu.src2_i[DATA_W-1]);
            neg_rem_q <= in_signed && in_div && mdu.src1_i[DATA_W-1];
            dbz_q     <= div_zero;
            opnd_q    <= in_div ? mag2 : mag1;
            // Early-out parks the dividend as the remainder with a zero quotient;
            // divide-by-zero keeps the raw dividend for the HI result.
            acc_hi_q  <= early_out ? mag1 : MDU_ZERO_WORD[DATA_W-1:0];
            if (early_out)
               acc_lo_q <= MDU_ZERO_WORD[DATA_W-1:0];
            else if (in_div)
               acc_lo_q <= div_zero ? mdu.src1_i : mag1;
            else
               acc_lo_q <= mag2;
         end else if (state_q == MDU_CALC) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            cnt_q    <= cnt_q - CNT_W'(1);
         end
      end
   end

   muldiv_step #(
      .DATA_W    (DATA_W),
      .STEP_BITS (STEP_BITS)
   ) u_step (
      .div_mode (div_q),
      .acc_hi   (acc_hi_q),
      .acc_lo   (acc_lo_q),
      .operand  (opnd_q),
      .next_hi  (step_hi),
      .next_lo  (step_lo)
   );

   assign prod_raw = {acc_hi_q, acc_lo_q};

   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         hi_q      <= MDU_ZERO_WORD[DATA_W-1:0];
         lo_q      <= MDU_ZERO_WORD[DATA_W-1:0];
         dbz_out_q <= 1'b0;
      end else if ((state_q == MDU_FIX) && !mdu.flush_i) begin
         if (dbz_q) begin
            hi_q      <= acc_lo_q;
            lo_q      <= '1;
            dbz_out_q <= 1'b1;
         end else if (div_q) begin
            hi_q      <= neg_rem_q ? -acc_hi_q : acc_hi_q;
            lo_q      <= neg_res_q ? -acc_lo_q : acc_lo_q;
            dbz_out_q <= 1'b0;
         end else begin
            {hi_q, lo_q} <= neg_res_q ? -prod_raw : prod_raw;
            dbz_out_q    <= 1'b0;
         end
      end
   end

   assign mdu.busy_o = (state_q == MDU_CALC) || (state_q == MDU_FIX);
   assign mdu.done_o = (state_q == MDU_DONE);
   assign mdu.hi_o   = hi_q;
   assign mdu.lo_o   = lo_q;
   assign mdu.dbz_o  = dbz_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table through a result scoreboard,
// plus flush, busy-start, back-to-back and mid-operation reset sequences.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   parameter int STEP_BITS = 2;
   localparam int DATA_W = 32;
   localparam int ITER   = DATA_W / STEP_BITS;
   localparam int NV     = 19;

   typedef struct {
      int          id;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          lat;
   } vec_t;

   logic cpu_clk_50M = 1'b0;
   logic cpu_rst_n;

   always #10 cpu_clk_50M = ~cpu_clk_50M;

   muldiv_unit_if #(.DATA_W(DATA_W)) mdu ();

   muldiv_unit #(
      .DATA_W    (DATA_W),
      .STEP_BITS (STEP_BITS)
   ) dut (
      .cpu_clk_50M (cpu_clk_50M),
      .cpu_rst_n   (cpu_rst_n),
      .mdu         (mdu)
   );

   int   checks = 0;
   int   errors = 0;
   vec_t sb_q[$];
   vec_t vecs[NV];
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      logic [31:0] ma, mb;
`endif
      if (op[1] == 1'b0) return ITER + 2;
      if (b == 32'd0) return 2;
`ifdef MULDIV_EARLY_OUT_EN
      ma = (op == 2'b10 && a[31]) ? -a : a;
      mb = (op == 2'b10 && b[31]) ? -b : b;
      if (ma < mb) return 2;
`endif
      return ITER + 2;
   endfunction

   function automatic vec_t mk(input int id, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                               input logic dbz);
      vec_t v;
      v.id = id; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dbz = dbz;
      v.lat = exp_lat(op, a, b);
      return v;
   endfunction

   // Drive start for one cycle from #1 after an edge; returns #1 after the accepting edge.
   task automatic issue(input vec_t v, input bit track);
      mdu.start_i = 1'b1;
      mdu.op_i    = v.op;
      mdu.src1_i  = v.a;
      mdu.src2_i  = v.b;
      if (track) sb_q.push_back(v);
      @(posedge cpu_clk_50M); #1;
      mdu.start_i = 1'b0;
      mdu.op_i    = 2'($urandom);
      mdu.src1_i  = $urandom;
      mdu.src2_i  = $urandom;
   endtask

   task automatic wait_done(input string tag, input int start_cyc);
      vec_t e;
      int   cyc;
      bit   busy_ok;
      cyc = start_cyc;
      busy_ok = 1'b1;
      while (!mdu.done_o && cyc <= 100) begin
         if (!mdu.busy_o) busy_ok = 1'b0;
         @(posedge cpu_clk_50M); #1;
         cyc++;
      end
      if (sb_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s_sb: scoreboard empty at done", tag);
         return;
      end
      e = sb_q.pop_front();
      check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
      check({tag, "_busy"}, {63'd0, busy_ok && !mdu.busy_o}, 64'd1);
      check({tag, "_hilo"}, {mdu.hi_o, mdu.lo_o}, {e.hi, e.lo});
      check({tag, "_dbz"}, {63'd0, mdu.dbz_o}, {63'd0, e.dbz});
      last_hi = e.hi;
      last_lo = e.lo;
   endtask

   task automatic watch_no_done(input string tag, input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge cpu_clk_50M); #1;
         if (mdu.done_o) seen++;
      end
      check({tag, "_no_done"}, 64'(seen), 64'd0);
      check({tag, "_held"}, {mdu.hi_o, mdu.lo_o}, {last_hi, last_lo});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(0,  2'b11, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0);
      vecs[1]  = mk(1,  2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   1'b0);
      vecs[2]  = mk(2,  2'b10, 32'h80000000,   32'hFFFFFFFF,   32'h0,          32'h80000000,   1'b0);
      vecs[3]  = mk(3,  2'b00, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFE,   1'b0);
      vecs[4]  = mk(4,  2'b01, 32'hFFFFFFFF,   32'd2,          32'h00000001,   32'hFFFFFFFE,   1'b0);
      vecs[5]  = mk(5,  2'b11, 32'd5,          32'd0,          32'd5,          32'hFFFFFFFF,   1'b1);
      vecs[6]  = mk(6,  2'b01, 32'd3,          32'd4,          32'd0,          32'd12,         1'b0);
      vecs[7]  = mk(7,  2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001,   1'b0);
      vecs[8]  = mk(8,  2'b11, 32'd3,          32'd10,         32'd3,          32'd0,          1'b0);
      vecs[9]  = mk(9,  2'b10, 32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   1'b0);
      vecs[10] = mk(10, 2'b10, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'hFFFFFFFF,   32'd3,          1'b0);
      vecs[11] = mk(11, 2'b10, 32'hFFFFFFFD,   32'd10,         32'hFFFFFFFD,   32'd0,          1'b0);
      vecs[12] = mk(12, 2'b00, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF,   32'hFFFFFFF1,   1'b0);
      vecs[13] = mk(13, 2'b10, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   32'hFFFFFFFF,   1'b1);
      vecs[14] = mk(14, 2'b11, 32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF,   1'b0);
      vecs[15] = mk(15, 2'b11, 32'h12345678,   32'h1000,       32'h678,        32'h12345,      1'b0);
      vecs[16] = mk(16, 2'b00, 32'h80000000,   32'h80000000,   32'h40000000,   32'h0,          1'b0);
      vecs[17] = mk(17, 2'b01, 32'd0,          32'h12345,      32'd0,          32'd0,          1'b0);
      vecs[18] = mk(18, 2'b11, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0);

      mdu.start_i = 1'b0;
      mdu.flush_i = 1'b0;
      mdu.op_i    = 2'b00;
      mdu.src1_i  = '0;
      mdu.src2_i  = '0;
      cpu_rst_n   = 1'b0;
      repeat (3) @(posedge cpu_clk_50M);
      #1;
      check("rst_busy", {63'd0, mdu.busy_o}, 64'd0);
      check("rst_done", {63'd0, mdu.done_o}, 64'd0);
      check("rst_dbz",  {63'd0, mdu.dbz_o},  64'd0);
      check("rst_hilo", {mdu.hi_o, mdu.lo_o}, 64'd0);
      cpu_rst_n = 1'b1;
      @(posedge cpu_clk_50M); #1;

      // Table: each new start lands in the DONE cycle of the previous op.
      for (int i = 0; i < NV; i++) begin
         issue(vecs[i], 1'b1);
         wait_done($sformatf("vec%0d", i), 1);
      end

      // Flush during CALC together with a start: nothing completes, results held.
      @(posedge cpu_clk_50M); #1;
      issue(mk(100, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0), 1'b0);
      repeat (4) @(posedge cpu_clk_50M);
      #1;
      mdu.flush_i = 1'b1;
      mdu.start_i = 1'b1;
      mdu.op_i    = 2'b01;
      mdu.src1_i  = 32'd3;
      mdu.src2_i  = 32'd4;
      @(posedge cpu_clk_50M); #1;
      check("flush_calc_busy", {63'd0, mdu.busy_o}, 64'd0);
      check("flush_calc_done", {63'd0, mdu.done_o}, 64'd0);
      check("flush_calc_held", {mdu.hi_o, mdu.lo_o}, {last_hi, last_lo});
      // Flush with start in IDLE: start is dropped.
      @(posedge cpu_clk_50M); #1;
      check("flush_start_busy", {63'd0, mdu.busy_o}, 64'd0);
      mdu.flush_i = 1'b0;
      mdu.start_i = 1'b0;
      issue(mk(101, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0), 1'b1);
      wait_done("after_flush", 1);

      // Start while busy is ignored and not queued.
      issue(mk(102, 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0), 1'b1);
      repeat (2) @(posedge cpu_clk_50M);
      #1;
      mdu.start_i = 1'b1;
      mdu.op_i    = 2'b11;
      mdu.src1_i  = 32'd100;
      mdu.src2_i  = 32'd7;
      @(posedge cpu_clk_50M); #1;
      mdu.start_i = 1'b0;
      wait_done("busy_ignored", 4);
      @(posedge cpu_clk_50M); #1;
      check("done_pulse", {62'd0, mdu.done_o, mdu.busy_o}, 64'd0);
      watch_no_done("no_queued", 40);

      // Asynchronous reset mid-operation clears outputs with no done.
      issue(mk(103, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0), 1'b0);
      repeat (5) @(posedge cpu_clk_50M);
      #3;
      cpu_rst_n = 1'b0;
      #1;
      check("midrst_busy", {63'd0, mdu.busy_o}, 64'd0);
      check("midrst_hilo", {mdu.hi_o, mdu.lo_o}, 64'd0);
      check("midrst_dbz",  {63'd0, mdu.dbz_o},  64'd0);
      @(posedge cpu_clk_50M); #1;
      cpu_rst_n = 1'b1;
      last_hi = '0;
      last_lo = '0;
      watch_no_done("midrst", 40);
      issue(mk(104, 2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0), 1'b1);
      wait_done("after_rst", 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
